// File: rtl/legv8_pkg.sv
// Shared LEGv8 constants and the data-memory responder FSM encoding.
package legv8_pkg;

  localparam int LEGV8_DATA_W = 64;
  localparam int WORD_BYTES   = 8;
  localparam int WORD_OFS_W   = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    MEM_IDLE      = 2'd0,
    MEM_RD_ACCESS = 2'd1,
    MEM_RD_DRIVE  = 2'd2
  } mem_state_e;

endpackage

// File: rtl/data_mem_array.sv
// Word-organised data RAM: synchronous write, combinational read, no reset.
module data_mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// RAM-side responder for the control unit's RCS/RR/WRR handshake: two-cycle
// LDUR reads with a registered bus enable, single-cycle STUR writes, sticky ERR.
module data_mem_responder
  import legv8_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = LEGV8_DATA_W
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              RCS,
  input  logic              RR,
  input  logic              WRR,
  input  logic [63:0]       ADDR,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] DOUT,
  output logic              DOUT_EN,
  output logic              BUSY,
  output logic              ERR
);

  mem_state_e        state;
  logic [ADDR_W-1:0] word_idx;
  logic              legal;
  logic              req_any, conflict, wr_req;
  logic              mem_we;
  logic [DATA_W-1:0] rdata;

  assign word_idx = ADDR[ADDR_W+WORD_OFS_W-1:WORD_OFS_W];
  // Anything above the array is an error, never aliased onto a lower word.
  assign legal    = (ADDR[WORD_OFS_W-1:0] == '0) &&
                    ((ADDR >> (ADDR_W + WORD_OFS_W)) == 64'd0);

  assign req_any  = RCS && (RR || WRR);
  assign conflict = RCS && RR && WRR;
  assign wr_req   = RCS && WRR && !RR;
  assign mem_we   = (state == MEM_IDLE) && wr_req && legal;

  data_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (CLK),
    .we    (mem_we),
    .addr  (word_idx),
    .wdata (DIN),
    .rdata (rdata)
  );

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state   <= MEM_IDLE;
      DOUT    <= '0;
      DOUT_EN <= 1'b0;
      BUSY    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (req_any) begin
            if (conflict || !legal) begin
              ERR <= 1'b1;
            end else if (RR) begin
              DOUT    <= rdata;
              DOUT_EN <= 1'b1;
              BUSY    <= 1'b1;
              state   <= MEM_RD_ACCESS;
            end
          end
        end
        MEM_RD_ACCESS: begin
          if (RCS && WRR) ERR <= 1'b1;
          if (RCS && RR) begin
            state <= MEM_RD_DRIVE;
          end else begin
            state   <= MEM_IDLE;
            DOUT_EN <= 1'b0;
            BUSY    <= 1'b0;
          end
        end
        MEM_RD_DRIVE: begin
          // DOUT is held, not re-read, so a moving ADDR cannot corrupt the bus.
          if (!(RCS && RR)) begin
            state   <= MEM_IDLE;
            DOUT_EN <= 1'b0;
            BUSY    <= 1'b0;
          end
        end
        default: begin
          state   <= MEM_IDLE;
          DOUT_EN <= 1'b0;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the control unit's RAM handshake (RCS/RR/WRR with an address from the ALU address bus).
- Serves LDUR reads with the two-cycle timing the control unit uses: RR is held for two cycles and register write happens in the second.
- Serves single-cycle STUR writes.
- Sits between the datapath address/data buses and a word-organised data RAM, and flags illegal accesses.

Parameters:
- ADDR_W, 8, word-address width (depth = 2^ADDR_W 64-bit words).
- DATA_W, 64, data word width. Fixed at 64 for LEGv8.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- Reset  input  1  synchronous, active-low reset; state is cleared on a posedge where Reset==0.
- RCS  input  1  RAM chip select from the control unit.
- RR  input  1  read request; qualified by RCS.
- WRR  input  1  write request; qualified by RCS.
- ADDR  input  64  byte address from the ALU address bus.
- DIN  input  64  store data, taken from the B bus.
- DOUT  output  64  read data toward the data bus.
- DOUT_EN  output  1  high when DOUT must drive the data bus.
- BUSY  output  1  high while a read is in progress.
- ERR  output  1  sticky illegal-access flag.

Behaviour:
- Decoding, per cycle:
  - Word index = ADDR[ADDR_W+2:3].
  - Access is legal only when ADDR[2:0]==0 and ADDR[63:ADDR_W+3]==0.
- Reset (Reset==0 at posedge):
  - state <= IDLE; DOUT <= 0; DOUT_EN <= 0; BUSY <= 0; ERR <= 0.
  - RAM contents are not cleared.
  - A reset during RD_ACCESS or RD_DRIVE aborts the read: no bus drive in the following cycle.
- FSM states: IDLE, RD_ACCESS, RD_DRIVE.
- IDLE:
  - RCS&RR&~WRR, legal: latch word into DOUT, go to RD_ACCESS, BUSY<=1.
  - RCS&WRR&~RR, legal: mem[index] <= DIN at this edge; stay IDLE. Write latency 1 cycle; no outputs change.
  - RCS&RR&WRR (conflict): no access, ERR<=1, stay IDLE.
  - Illegal address with RCS&(RR|WRR): no access, ERR<=1, DOUT unchanged.
  - RCS==0: RR/WRR are ignored.
- RD_ACCESS (second cycle of LDUR):
  - DOUT_EN=1 and DOUT holds the word latched at the request edge. Data is valid for the control unit's WR cycle.
  - Next edge: RCS&RR still high goes to RD_DRIVE; otherwise to IDLE with DOUT_EN<=0, BUSY<=0.
  - A WRR arriving in this state is ignored and sets ERR.
- RD_DRIVE: stale-hold guard.
  - DOUT_EN stays 1 while RCS&RR remain high.
  - Data is not re-read even if ADDR changes.
  - Returns to IDLE when RR or RCS drops.
- Read latency: request sampled at edge N; DOUT valid from edge N to edge N+2.
- Write-then-read to the same word on consecutive cycles returns the new data (write completes at edge N, read samples at edge N+1).
- ERR is sticky until reset.
- DOUT_EN is a registered output, so the bus enable is glitch-free.
- Address wrap-around is not supported: out-of-range is an error, never aliased.

Decomposition:
- Shared package (legv8_pkg):
  - State encoding constants MEM_IDLE=2'd0, MEM_RD_ACCESS=2'd1, MEM_RD_DRIVE=2'd2.
  - WORD_BYTES=8.
  - LEGv8 data width constant 64.
- One sub-module: data_mem_array.
  - Synchronous-write, combinational-read 2^ADDR_W x 64 array.
  - No reset.
  - Keeps the FSM and legality checks separate from storage.

Test Plan:
- Write/read-back: Reset=0 for 2 cycles, then high. WRR=1,RCS=1,ADDR=0x10,DIN=0xDEADBEEF_CAFEF00D for one cycle. Then RR=1,RCS=1,ADDR=0x10 for two cycles -> DOUT=0xDEADBEEFCAFEF00D with DOUT_EN=1 in the second cycle, DOUT_EN=0 after RR drops, ERR=0.
- Misaligned: RR=1,RCS=1,ADDR=0x13 -> no FSM transition, DOUT_EN stays 0, ERR=1 and remains 1 on later legal accesses until Reset=0.
- Out-of-range: with ADDR_W=8, WRR=1,RCS=1,ADDR=0x800,DIN=5 -> ERR=1; a subsequent read of ADDR=0x0 returns the prior contents unchanged (no aliasing).
- Conflict and chip-select gating:
  - RR=1,WRR=1,RCS=1 -> ERR=1, no write occurs (read-back of that address is unchanged).
  - RR=1 with RCS=0 -> DOUT_EN=0, BUSY=0.
- Held read/address change: RR held 4 cycles; ADDR switched from 0x8 to 0x18 after cycle 1 -> DOUT keeps mem[1] for all driven cycles, DOUT_EN=1 cycles 2-4, then 0.
- Reset mid-read: start read at ADDR=0x8, assert Reset=0 during RD_ACCESS -> next cycle DOUT_EN=0, BUSY=0, DOUT=0, state IDLE; memory word at 0x8 is intact on re-read.
